// File: rtl/clock_display_scan.sv
// clock_display_scan: time-multiplexed 4-digit common-anode 7-segment driver for a packed BCD mm:ss word.
// Ports: clk/rst (sync, active-high); min_sec packed BCD time {mt,mo,st,so}; lz_blank hides a zero
// minute-tens digit; an active-low digit enables (an[0] = sec ones); seg active-low {g,f,e,d,c,b,a};
// dp active-low colon, lit only on digit 2.
module clock_display_scan #(
    parameter int SCAN_DIV    = 1000,
    parameter int GAP         = 16,
    parameter int BLINK_SCANS = 128
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] min_sec,
    input  logic        lz_blank,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);
    localparam int CW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
    localparam int BW = $clog2(BLINK_SCANS + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    idx_q, idx_d;
    logic [BW-1:0] scan_q, scan_d;
    logic          ph_q, ph_d;
    logic [15:0]   hold_q, hold_d;
    logic          first_q, first_d;
    logic [3:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;
    logic          slot_end, wrap, blink_end, blank;
    logic [3:0]    nib;

    function automatic logic [6:0] decode(input logic [3:0] n);
        case (n)
            4'd0:    decode = 7'b1000000;
            4'd1:    decode = 7'b1111001;
            4'd2:    decode = 7'b0100100;
            4'd3:    decode = 7'b0110000;
            4'd4:    decode = 7'b0011001;
            4'd5:    decode = 7'b0010010;
            4'd6:    decode = 7'b0000010;
            4'd7:    decode = 7'b1111000;
            4'd8:    decode = 7'b0000000;
            4'd9:    decode = 7'b0010000;
            default: decode = 7'b0111111;
        endcase
    endfunction

    always_comb begin
        slot_end  = cnt_q == CW'(SCAN_DIV - 1);
        wrap      = slot_end && idx_q == 2'd3;
        blink_end = scan_q == BW'(BLINK_SCANS - 1);
        cnt_d     = slot_end ? '0 : cnt_q + 1'b1;
        idx_d     = slot_end ? idx_q + 2'd1 : idx_q;
        scan_d    = wrap ? (blink_end ? '0 : scan_q + 1'b1) : scan_q;
        ph_d      = (wrap && blink_end) ? ~ph_q : ph_q;
        // the hold register only changes between scans, so a scan never mixes two times
        hold_d    = (wrap || first_q) ? min_sec : hold_q;
        first_d   = 1'b0;
        nib       = hold_q[4*idx_q +: 4];
        blank     = 32'(cnt_q) < GAP || (idx_q == 2'd3 && lz_blank && nib == 4'd0) ||
                    (hold_q == 16'h0000 && ph_q);
        an_d      = blank ? 4'hF : ~(4'b0001 << idx_q);
        seg_d     = blank ? 7'h7F : decode(nib);
        dp_d      = !(idx_q == 2'd2 && !blank && !ph_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            scan_q  <= '0;
            ph_q    <= 1'b0;
            hold_q  <= 16'h0000;
            first_q <= 1'b1;
            an_q    <= 4'hF;
            seg_q   <= 7'h7F;
            dp_q    <= 1'b1;
        end else begin
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            scan_q  <= scan_d;
            ph_q    <= ph_d;
            hold_q  <= hold_d;
            first_q <= first_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = dp_q;
endmodule

// File: tb/tb_clock_display_scan.sv
// tb_clock_display_scan: scoreboard bench for clock_display_scan with SCAN_DIV=8, GAP=2, BLINK_SCANS=2.
module tb_clock_display_scan;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] min_sec = 16'h1234;
    logic        lz_blank = 1'b0;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;

    int n_tests = 0;
    int n_fail  = 0;
    int t = 0;
    logic [15:0] m_hold = 16'h0000;
    logic [6:0]  dec [16];
    logic [11:0] exp_q [$];

    clock_display_scan #(.SCAN_DIV(8), .GAP(2), .BLINK_SCANS(2)) dut (
        .clk(clk), .rst(rst), .min_sec(min_sec), .lz_blank(lz_blank),
        .an(an), .seg(seg), .dp(dp)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [11:0] got, input logic [11:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s t=%0d got=%h want=%h", tag, t, got, want);
        end
    endtask

    initial begin
        dec[0] = 7'b1000000; dec[1] = 7'b1111001; dec[2] = 7'b0100100; dec[3] = 7'b0110000;
        dec[4] = 7'b0011001; dec[5] = 7'b0010010; dec[6] = 7'b0000010; dec[7] = 7'b1111000;
        dec[8] = 7'b0000000; dec[9] = 7'b0010000;
        for (int i = 10; i < 16; i++) dec[i] = 7'b0111111;
    end

    // Reference: t counts non-reset edges; slot, digit and scan position follow from t alone.
    always @(posedge clk) begin
        logic [3:0] e_an, e_nib;
        logic [6:0] e_seg;
        logic       e_dp, e_blank, e_ph;
        int         e_idx;
        if (rst) begin
            t = 0;
            m_hold = 16'h0000;
            exp_q.push_back({4'hF, 7'h7F, 1'b1});
        end else begin
            e_idx   = (t / 8) % 4;
            e_ph    = ((t / 64) % 2) == 1;
            e_nib   = 4'((m_hold >> (4 * e_idx)) & 16'hF);
            e_blank = (t % 8) < 2 || (e_idx == 3 && lz_blank && e_nib == 0) || (m_hold == 0 && e_ph);
            e_an    = e_blank ? 4'hF : 4'hF ^ (4'b0001 << e_idx);
            e_seg   = e_blank ? 7'h7F : dec[e_nib];
            e_dp    = !(e_idx == 2 && !e_blank && !e_ph);
            exp_q.push_back({e_an, e_seg, e_dp});
            if (t == 0 || t % 32 == 31) m_hold = min_sec;
            t++;
        end
    end

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            check("out", {an, seg, dp}, exp_q.pop_front());
            check("an_onehot", 12'($countones(~an) <= 1), 12'd1);
        end
    end

    initial begin
        int lit;
        repeat (3) @(negedge clk);
        check("rst_an", {8'h0, an}, 12'h00F);
        check("rst_segdp", {4'h0, seg, dp}, {4'h0, 7'h7F, 1'b1});
        rst = 1'b0;
        lit = 0;
        for (int i = 1; i <= 20 && lit == 0; i++) begin
            @(negedge clk);
            if (an != 4'hF) lit = i;
        end
        check("first_lit", 12'(lit), 12'd3);
        repeat (60) @(negedge clk);
        // reset in the middle of a slot
        repeat (13) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        // change the time while digit 1 is being shown
        while ((t % 32) != 10) @(negedge clk);
        min_sec = 16'h5959;
        repeat (60) @(negedge clk);
        min_sec = 16'h0930;
        lz_blank = 1'b1;
        repeat (64) @(negedge clk);
        lz_blank = 1'b0;
        repeat (64) @(negedge clk);
        min_sec = 16'h0000;
        repeat (200) @(negedge clk);
        min_sec = 16'h0A00;
        repeat (70) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
